// File: rtl/hdlc_pkg.sv
// Shared HDLC framing constants, hold-buffer depth and receive state encoding.
// Hold depth depends on HDLC_RX_FCS_EN (3 when the FCS is checked, otherwise 1).
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG = 8'h7E;
    localparam logic [7:0]  HDLC_ESC  = 8'h7D;
    localparam logic [7:0]  HDLC_XOR  = 8'h20;
    localparam logic [15:0] FCS_INIT  = 16'hFFFF;
    localparam logic [15:0] FCS_POLY  = 16'h8408;
    localparam logic [15:0] FCS_GOOD  = 16'hF0B8;

`ifdef HDLC_RX_FCS_EN
    localparam int HOLD_DEPTH = 3;
`else
    localparam int HOLD_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        HUNT,
        IDLE,
        DATA,
        ESC
    } hdlc_state_t;

endpackage

// File: rtl/hdlc_fcs16.sv
// Combinational byte-wise CRC-16/CCITT update, LSB first (reflected poly 0x8408).
// Shared between the receive deframer and the transmit framer.
module hdlc_fcs16
    import hdlc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ FCS_POLY) : (crc_work >> 1);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// RFC1662-style receive deframer: strips flags/escapes, delays bytes through a hold
// buffer so the trailing FCS can be dropped. Define HDLC_RX_FCS_EN to check the FCS.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_strobe,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_end,
    output logic             frame_err,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    localparam int H          = HOLD_DEPTH;
    localparam int BUF_CNT_W  = $clog2(H + 1);
    // Stored bytes include the H-1 FCS bytes still sitting in the buffer at close.
    localparam int STORED_MAX = MAX_LEN + H - 1;
    localparam int STORED_W   = $clog2(STORED_MAX + 1);

    hdlc_state_t          state;
    hdlc_state_t          state_nxt;
    logic [7:0]           hold_buf [H];
    logic [BUF_CNT_W-1:0] buf_cnt;
    logic [STORED_W-1:0]  stored_cnt;
    logic                 first_pending;

    logic                 store_en;
    logic                 close_en;
    logic                 abort_en;
    logic                 overflow;
    logic [7:0]           store_byte;
    logic                 buf_full;
    logic                 fcs_bad;
    logic                 end_en;
    logic                 err_nxt;

    assign buf_full = (buf_cnt == BUF_CNT_W'(H));
    assign end_en   = close_en | abort_en | overflow;
    assign err_nxt  = close_en ? (!buf_full || fcs_bad) : 1'b1;

    always_comb begin
        state_nxt  = state;
        store_en   = 1'b0;
        close_en   = 1'b0;
        abort_en   = 1'b0;
        overflow   = 1'b0;
        store_byte = in_data;
        if (in_strobe) begin
            case (state)
                HUNT: begin
                    if (in_data == HDLC_FLAG) state_nxt = IDLE;
                end
                IDLE: begin
                    if (in_data == HDLC_ESC) begin
                        state_nxt = ESC;
                    end else if (in_data != HDLC_FLAG) begin
                        store_en  = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (in_data == HDLC_FLAG) begin
                        close_en  = 1'b1;
                        state_nxt = IDLE;
                    end else if (in_data == HDLC_ESC) begin
                        state_nxt = ESC;
                    end else begin
                        store_en = 1'b1;
                    end
                end
                ESC: begin
                    if (in_data == HDLC_FLAG) begin
                        abort_en  = (stored_cnt != '0);
                        state_nxt = IDLE;
                    end else begin
                        store_en   = 1'b1;
                        store_byte = in_data ^ HDLC_XOR;
                        state_nxt  = DATA;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        overflow = store_en && (stored_cnt == STORED_W'(STORED_MAX));
        if (overflow) state_nxt = HUNT;
    end

`ifdef HDLC_RX_FCS_EN
    logic [15:0] crc;
    logic [15:0] crc_base;
    logic [15:0] crc_next;

    // An empty frame restarts the CRC from the init value rather than the stale residue.
    assign crc_base = (stored_cnt == '0) ? FCS_INIT : crc;
    assign fcs_bad  = (crc != FCS_GOOD);

    hdlc_fcs16 u_fcs (
        .crc_in  (crc_base),
        .data_in (store_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge mclk or posedge reset) begin
        if (reset)         crc <= FCS_INIT;
        else if (store_en) crc <= crc_next;
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            buf_cnt       <= '0;
            stored_cnt    <= '0;
            first_pending <= 1'b1;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_eof       <= 1'b0;
            frame_end     <= 1'b0;
            frame_err     <= 1'b0;
            frames_ok     <= '0;
            frames_bad    <= '0;
            for (int i = 0; i < H; i++) hold_buf[i] <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_end <= end_en;
            frame_err <= end_en & err_nxt;

            if ((store_en || close_en) && buf_full) begin
                out_valid     <= 1'b1;
                out_data      <= hold_buf[0];
                out_sof       <= first_pending;
                out_eof       <= close_en;
                first_pending <= 1'b0;
            end

            if (end_en) begin
                buf_cnt       <= '0;
                stored_cnt    <= '0;
                first_pending <= 1'b1;
            end else if (store_en) begin
                stored_cnt <= stored_cnt + STORED_W'(1);
                if (buf_full) begin
                    for (int i = 0; i < H; i++)
                        hold_buf[i] <= (i == H - 1) ? store_byte : hold_buf[(i + 1) % H];
                end else begin
                    for (int i = 0; i < H; i++)
                        if (buf_cnt == BUF_CNT_W'(i)) hold_buf[i] <= store_byte;
                    buf_cnt <= buf_cnt + BUF_CNT_W'(1);
                end
            end

            if (end_en && !err_nxt && (frames_ok != '1))
                frames_ok <= frames_ok + CNT_W'(1);
            if (end_en && err_nxt && (frames_bad != '1))
                frames_bad <= frames_bad + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer (MAX_LEN=4); covers the FCS build when
// HDLC_RX_FCS_EN is defined, otherwise the plain flag/escape/overflow behaviour.
module tb_hdlc_rx_deframer;

    logic        mclk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_strobe;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        frame_end;
    logic        frame_err;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    hdlc_rx_deframer #(.MAX_LEN(4), .CNT_W(16)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_end  (frame_end),
        .frame_err  (frame_err),
        .frames_ok  (frames_ok),
        .frames_bad (frames_bad)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge mclk);
        in_data   = b;
        in_strobe = 1'b1;
        @(negedge mclk);
        in_strobe = 1'b0;
    endtask

    // Sampled on the negedge after the strobe, then again one cycle later to prove the pulses drop.
    task automatic checkOutput(input string tag, input logic ev, input logic [7:0] ed,
                               input logic es, input logic ee, input logic eend, input logic eerr);
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".end"}, 32'(frame_end), 32'(eend));
        if (ev) begin
            check({tag, ".data"}, 32'(out_data), 32'(ed));
            check({tag, ".sof"}, 32'(out_sof), 32'(es));
            check({tag, ".eof"}, 32'(out_eof), 32'(ee));
        end
        if (eend) check({tag, ".err"}, 32'(frame_err), 32'(eerr));
        @(negedge mclk);
        if (ev || eend) check({tag, ".pulse"}, 32'({out_valid, frame_end}), 32'(0));
        repeat (4) @(negedge mclk);
    endtask

    task automatic step(input string tag, input logic [7:0] b, input logic ev, input logic [7:0] ed,
                        input logic es, input logic ee, input logic eend, input logic eerr);
        applyStimulus(b);
        checkOutput(tag, ev, ed, es, ee, eend, eerr);
    endtask

    task automatic stepNone(input string tag, input logic [7:0] b);
        step(tag, b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkCounters(input string tag, input int ok, input int bad);
        check({tag, ".ok"}, 32'(frames_ok), 32'(ok));
        check({tag, ".bad"}, 32'(frames_bad), 32'(bad));
    endtask

`ifdef HDLC_RX_FCS_EN
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    task automatic sendEscaped(input string tag, input logic [7:0] b, input logic ev,
                               input logic [7:0] ed, input logic es);
        if (b == 8'h7E || b == 8'h7D) begin
            stepNone({tag, ".esc"}, 8'h7D);
            step(tag, b ^ 8'h20, ev, ed, es, 1'b0, 1'b0, 1'b0);
        end else begin
            step(tag, b, ev, ed, es, 1'b0, 1'b0, 1'b0);
        end
    endtask
`endif

    initial begin
`ifdef HDLC_RX_FCS_EN
        logic [15:0] crc;
        logic [15:0] fcs;
`endif
        reset     = 1'b1;
        in_strobe = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge mclk);
        check("rst.outs", 32'({out_valid, out_sof, out_eof, frame_end, frame_err}), 32'(0));
        check("rst.data", 32'(out_data), 32'(0));
        checkCounters("rst", 0, 0);
        reset = 1'b0;
        repeat (3) @(negedge mclk);

`ifdef HDLC_RX_FCS_EN
        crc = crcByte(crcByte(16'hFFFF, 8'h01), 8'h02);
        fcs = ~crc;

        stepNone("f1.flag", 8'h7E);
        stepNone("f1.b01", 8'h01);
        stepNone("f1.b02", 8'h02);
        sendEscaped("f1.lo", fcs[7:0], 1'b0, 8'h00, 1'b0);
        sendEscaped("f1.hi", fcs[15:8], 1'b1, 8'h01, 1'b1);
        step("f1.close", 8'h7E, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCounters("f1", 1, 0);

        stepNone("f2.b01", 8'h01);
        stepNone("f2.b02", 8'h02);
        sendEscaped("f2.lo", fcs[7:0] ^ 8'h01, 1'b0, 8'h00, 1'b0);
        sendEscaped("f2.hi", fcs[15:8], 1'b1, 8'h01, 1'b1);
        step("f2.close", 8'h7E, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCounters("f2", 1, 1);

        stepNone("f3.b01", 8'h01);
        step("f3.runt", 8'h7E, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCounters("f3", 1, 2);
`else
        stepNone("t1.hunt41", 8'h41);
        stepNone("t1.flag", 8'h7E);
        stepNone("t1.flag2", 8'h7E);
        stepNone("t1.b01", 8'h01);
        step("t1.b02", 8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t1.b03", 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1.close", 8'h7E, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCounters("t1", 1, 0);

        stepNone("t2.flag", 8'h7E);
        stepNone("t2.esc1", 8'h7D);
        stepNone("t2.5e", 8'h5E);
        stepNone("t2.esc2", 8'h7D);
        step("t2.5d", 8'h5D, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2.close", 8'h7E, 1'b1, 8'h7D, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCounters("t2", 2, 0);

        stepNone("t3.flag", 8'h7E);
        stepNone("t3.b01", 8'h01);
        step("t3.b02", 8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        stepNone("t3.esc", 8'h7D);
        step("t3.abort", 8'h7E, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCounters("t3a", 2, 1);
        stepNone("t3.b05", 8'h05);
        step("t3.close", 8'h7E, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCounters("t3b", 3, 1);

        stepNone("t4.escempty", 8'h7D);
        stepNone("t4.flagempty", 8'h7E);
        checkCounters("t4", 3, 1);

        stepNone("t5.b01", 8'h01);
        step("t5.b02", 8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5.b03", 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5.b04", 8'h04, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5.ovf", 8'h05, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCounters("t5a", 3, 2);
        stepNone("t5.hunt06", 8'h06);
        stepNone("t5.hunt7d", 8'h7D);
        stepNone("t5.flag", 8'h7E);
        stepNone("t5.b09", 8'h09);
        step("t5.close", 8'h7E, 1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCounters("t5b", 4, 2);

        stepNone("t6.aa", 8'hAA);
        step("t6.bb", 8'hBB, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge mclk);
        reset     = 1'b1;
        in_data   = 8'h7E;
        in_strobe = 1'b1;
        @(negedge mclk);
        in_strobe = 1'b0;
        @(negedge mclk);
        check("t6.rst", 32'({out_valid, frame_end, frame_err}), 32'(0));
        checkCounters("t6rst", 0, 0);
        reset = 1'b0;
        repeat (3) @(negedge mclk);
        check("t6.noend", 32'(frame_end), 32'(0));
        stepNone("t6.flag", 8'h7E);
        stepNone("t6.cc", 8'hCC);
        step("t6.close", 8'h7E, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b0);
        checkCounters("t6", 1, 0);
`endif

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
